dat_mem_mover: RTL and testbench

- Block-copy engine acting as the initiator/master on the data-memory port: drives address, write enable and write data; consumes combinational read data.
- Copies `len` bytes from `src_addr` to `dst_addr`, one byte per two cycles (read cycle, then write cycle).
- Sits beside the processor's load/store path; a mux outside this block selects which master owns the memory while `busy` is high.

---
 rtl/dat_mem_mover.sv | 104 ++++++++++
 tb/tb_dat_mem_mover.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_mover.sv
// Block-copy engine: moves len bytes from src_addr to dst_addr over the data-memory port,
// one read cycle followed by one write cycle per byte.
module dat_mem_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] remaining;
    logic [DW-1:0] data_q;

    // Handshake: start is a request sampled only in IDLE (no ready signal; a start seen in
    // any other state is dropped). done is a one-cycle completion pulse, busy marks ownership
    // of the memory port for the whole READ/WRITE sequence.
    // Port outputs are registered with the value belonging to the state being entered,
    // so the memory port never sees a combinational path from the request inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            data_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_wr_en  <= 1'b0;
            mem_dat_in <= '0;
        end else begin
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_wr_en  <= 1'b0;
            mem_dat_in <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        if (len != '0) begin
                            state    <= READ;
                            busy     <= 1'b1;
                            mem_addr <= src_addr;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    data_q     <= mem_dat_out;
                    src_ptr    <= src_ptr + 1'b1;
                    state      <= WRITE;
                    busy       <= 1'b1;
                    mem_addr   <= dst_ptr;
                    mem_wr_en  <= 1'b1;
                    mem_dat_in <= mem_dat_out;
                end
                WRITE: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == {{(AW-1){1'b0}}, 1'b1}) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= READ;
                        busy     <= 1'b1;
                        mem_addr <= src_ptr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_mem_mover.sv
// Bench for dat_mem_mover: behavioural byte memory, write scoreboard fed from a shadow
// copy model, and per-scenario tasks checking timing, results and boundary cases.
module tb_dat_mem_mover;
  localparam int AW = 8;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_dat_in;
  logic [DW-1:0] mem_dat_out;

  dat_mem_mover #(.AW(AW), .DW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en),
    .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  // memory model with a bench-side preload port
  logic [DW-1:0] mem [256];
  logic [DW-1:0] shadow [256];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign mem_dat_out = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  end

  // scoreboard: expected {addr, data} of every memory write, in order
  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q [$];
  logic [AW+DW-1:0] mon_e;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, mem_dat_in);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_dat_in} !== mon_e) begin
          bad++;
          $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_dat_in, mon_e[15:8], mon_e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'(i * 7 + 3));
  endtask

  task automatic snap_shadow();
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
  endtask

  // forward bytewise reference copy on the shadow; pushes the writes it performs
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] sa, da, b;
    for (int i = 0; i < n; i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      b = shadow[sa];
      shadow[da] = b;
      exp_q.push_back({da, b});
    end
  endtask

  task automatic check_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL %s_mem: got %0d differing bytes, expected 0", name, diffs);
    end
  endtask

  // runs one copy and checks busy length, done timing/count, scoreboard drain and memory
  task automatic do_copy(input string name, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input bit interfere);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    int n_i = int'(n);
    snap_shadow();
    model_copy(s, d, n_i);
    src_addr = s;
    dst_addr = d;
    len = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = 8'($urandom_range(0, 255));
    dst_addr = 8'($urandom_range(0, 255));
    len = 8'($urandom_range(1, 255));
    for (int c = 1; c <= 2 * n_i + 4; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (interfere && (c == 3 || c == 2 * n_i + 1)) begin
        start = 1'b1;
        src_addr = 8'd200;
        dst_addr = 8'd210;
        len = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (busy_cnt != 2 * n_i) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, busy_cnt, 2 * n_i);
    end
    total++;
    if (done_cnt != 1 || done_at != 2 * n_i + 1) begin
      bad++;
      $display("FAIL %s_done: got count=%0d cycle=%0d, expected count=1 cycle=%0d",
               name, done_cnt, done_at, 2 * n_i + 1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes: got %0d pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check_mem(name);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    src_addr = 8'd1;
    len = 8'd4;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, mem_wr_en, mem_addr, mem_dat_in} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%h din=%h, expected all 0",
               busy, done, mem_wr_en, mem_addr, mem_dat_in);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_with_start: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] keep;
    poke(8'd60, 8'h10);
    poke(8'd61, 8'hE0);
    poke(8'd62, 8'hF0);
    keep = mem[103];
    do_copy("basic", 8'd60, 8'd100, 8'd3, 1'b0);
    total++;
    if (mem[100] !== 8'h10 || mem[101] !== 8'hE0 || mem[102] !== 8'hF0 || mem[103] !== keep) begin
      bad++;
      $display("FAIL basic_bytes: got %h %h %h %h, expected 10 e0 f0 %h",
               mem[100], mem[101], mem[102], mem[103], keep);
    end
  endtask

  task automatic test_len_zero();
    do_copy("len_zero", 8'd5, 8'd9, 8'd0, 1'b0);
  endtask

  task automatic test_wrap();
    poke(8'd254, 8'hAA);
    poke(8'd255, 8'hBB);
    poke(8'd0, 8'hCC);
    do_copy("wrap_src", 8'd254, 8'd10, 8'd3, 1'b0);
    total++;
    if (mem[10] !== 8'hAA || mem[11] !== 8'hBB || mem[12] !== 8'hCC) begin
      bad++;
      $display("FAIL wrap_src_bytes: got %h %h %h, expected aa bb cc", mem[10], mem[11], mem[12]);
    end
    poke(8'd30, 8'h31);
    poke(8'd31, 8'h32);
    do_copy("wrap_dst", 8'd30, 8'd255, 8'd2, 1'b0);
    total++;
    if (mem[255] !== 8'h31 || mem[0] !== 8'h32) begin
      bad++;
      $display("FAIL wrap_dst_bytes: got %h %h, expected 31 32", mem[255], mem[0]);
    end
  endtask

  task automatic test_overlap();
    poke(8'd20, 8'h55);
    do_copy("overlap", 8'd20, 8'd21, 8'd4, 1'b0);
    total++;
    if (mem[21] !== 8'h55 || mem[22] !== 8'h55 || mem[23] !== 8'h55 || mem[24] !== 8'h55) begin
      bad++;
      $display("FAIL overlap_fill: got %h %h %h %h, expected 55 55 55 55",
               mem[21], mem[22], mem[23], mem[24]);
    end
  endtask

  task automatic test_start_while_busy();
    do_copy("start_busy", 8'd70, 8'd150, 8'd5, 1'b1);
  endtask

  task automatic test_same_addr();
    do_copy("same_addr", 8'd90, 8'd90, 8'd3, 1'b0);
  endtask

  task automatic test_reset_mid_copy();
    int done_cnt = 0;
    snap_shadow();
    model_copy(8'd40, 8'd140, 3);
    src_addr = 8'd40;
    dst_addr = 8'd140;
    len = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 8'd142) begin
      bad++;
      $display("FAIL rst_mid_third_write: got we=%b addr=%0d, expected we=1 addr=142", mem_wr_en, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mem_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_after: got we=%b busy=%b done=%b, expected 0 0 0", mem_wr_en, busy, done);
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_no_done: got done pulses=%0d busy=%b, expected 0 0", done_cnt, busy);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_mid_writes: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    check_mem("rst_mid");
    do_copy("after_reset", 8'd40, 8'd140, 8'd5, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_copy("b2b_a", 8'd110, 8'd180, 8'd4, 1'b0);
    do_copy("b2b_b", 8'd180, 8'd220, 8'd4, 1'b0);
    for (int k = 0; k < 3; k++)
      do_copy("b2b_rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(1, 12)), 1'b0);
  endtask

  initial begin
    test_reset();
    init_mem();
    test_basic();
    test_len_zero();
    test_wrap();
    test_overlap();
    test_start_while_busy();
    test_same_addr();
    test_reset_mid_copy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
